// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising two masters onto a single-outstanding RRdy/RVld memory bus.
// Define ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles, answering with zero data and RErr.
module mem_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rstn,
  // Master 0: instruction fetch
  input  logic          M0Req,
  input  logic [AW-1:0] M0Addr,
  input  logic [DW-1:0] M0WData,
  input  logic          M0WEn,
  output logic          M0Vld,
  output logic [DW-1:0] M0Data,
  // Master 1: load/store
  input  logic          M1Req,
  input  logic [AW-1:0] M1Addr,
  input  logic [DW-1:0] M1WData,
  input  logic          M1WEn,
  output logic          M1Vld,
  output logic [DW-1:0] M1Data,
  // Memory side
  output logic          RRdy,
  output logic [AW-1:0] RAddr,
  output logic [DW-1:0] RWData,
  output logic          RWEn,
  input  logic          RVld,
  input  logic [DW-1:0] RData,
  output logic          RErr
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_rrdy;
  logic [AW-1:0] r_raddr;
  logic [DW-1:0] r_rwdata;
  logic          r_rwen;
  logic          r_m0_vld;
  logic          r_m1_vld;
  logic [DW-1:0] r_m0_data;
  logic [DW-1:0] r_m1_data;

  logic          w_req_any;
  logic          w_grant;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_wen;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic            r_rerr;
  logic [CntW-1:0] r_tmo_cnt;
`else
  // TIMEOUT has no effect without the watchdog; referenced here only to keep it elaborated.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // On a tie the master that was not served last wins; a lone request always wins.
  assign w_req_any = M0Req | M1Req;
  assign w_grant   = (M0Req & M1Req) ? ~r_last : M1Req;
  assign w_addr    = w_grant ? M1Addr  : M0Addr;
  assign w_wdata   = w_grant ? M1WData : M0WData;
  assign w_wen     = w_grant ? M1WEn   : M0WEn;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_rrdy    <= 1'b0;
      r_raddr   <= '0;
      r_rwdata  <= '0;
      r_rwen    <= 1'b0;
      r_m0_vld  <= 1'b0;
      r_m1_vld  <= 1'b0;
      r_m0_data <= '0;
      r_m1_data <= '0;
`ifdef ARB_TIMEOUT_EN
      r_rerr    <= 1'b0;
      r_tmo_cnt <= '0;
`endif
    end else begin
      // Strobes are single-cycle; only the state that raises them holds them for one cycle.
      r_rrdy   <= 1'b0;
      r_m0_vld <= 1'b0;
      r_m1_vld <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_rerr   <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (w_req_any) begin
            r_owner  <= w_grant;
            r_last   <= w_grant;
            r_raddr  <= w_addr;
            r_rwdata <= w_wdata;
            r_rwen   <= w_wen;
            r_rrdy   <= 1'b1;
            r_state  <= StIssue;
          end
        end
        StIssue: begin
          r_rwen  <= 1'b0;
          r_state <= StWait;
`ifdef ARB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        StWait: begin
          if (RVld) begin
            if (r_owner) begin
              r_m1_data <= RData;
              r_m1_vld  <= 1'b1;
            end else begin
              r_m0_data <= RData;
              r_m0_vld  <= 1'b1;
            end
            r_state <= StResp;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_tmo_cnt == CntW'(TIMEOUT - 1)) begin
            if (r_owner) begin
              r_m1_data <= '0;
              r_m1_vld  <= 1'b1;
            end else begin
              r_m0_data <= '0;
              r_m0_vld  <= 1'b1;
            end
            r_rerr  <= 1'b1;
            r_state <= StResp;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CntW'(1);
          end
`endif
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign RRdy   = r_rrdy;
  assign RAddr  = r_raddr;
  assign RWData = r_rwdata;
  assign RWEn   = r_rwen;
  assign M0Vld  = r_m0_vld;
  assign M1Vld  = r_m1_vld;
  assign M0Data = r_m0_data;
  assign M1Data = r_m1_data;
`ifdef ARB_TIMEOUT_EN
  assign RErr   = r_rerr;
`else
  assign RErr   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected bus issues and
// responses; a negedge monitor pops and compares whenever the DUT strobes RRdy or MxVld.
module tb_mem_bus_arbiter;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        M0Req = 1'b0, M1Req = 1'b0;
  logic [31:0] M0Addr = '0, M1Addr = '0, M0WData = '0, M1WData = '0;
  logic        M0WEn = 1'b0, M1WEn = 1'b0;
  logic        M0Vld, M1Vld;
  logic [31:0] M0Data, M1Data;
  logic        RRdy, RWEn, RErr;
  logic [31:0] RAddr, RWData;
  logic        RVld = 1'b0;
  logic [31:0] RData = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .M0Req(M0Req), .M0Addr(M0Addr), .M0WData(M0WData), .M0WEn(M0WEn),
    .M0Vld(M0Vld), .M0Data(M0Data),
    .M1Req(M1Req), .M1Addr(M1Addr), .M1WData(M1WData), .M1WEn(M1WEn),
    .M1Vld(M1Vld), .M1Data(M1Data),
    .RRdy(RRdy), .RAddr(RAddr), .RWData(RWData), .RWEn(RWEn),
    .RVld(RVld), .RData(RData), .RErr(RErr)
  );

  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic wen; int cyc;} iss_t;
  typedef struct {logic [31:0] data; logic err; int cyc;} rsp_t;

  iss_t iq[$];
  rsp_t rq0[$];
  rsp_t rq1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   base  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory stub: latency mem_lat cycles after RRdy; 0 means never respond.
  logic [31:0] mem [0:511];
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_rd  = '0;

  always @(posedge clk) begin : p_mem
    logic [31:0] rd_v;
    RVld <= 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        RVld  <= 1'b1;
        RData <= mem_rd;
      end
    end
    if (RRdy && mem_lat > 0) begin
      if (RWEn) begin
        mem[RAddr[8:0]] <= RWData;
        rd_v = 32'hBAD0_0000 | RAddr;
      end else begin
        rd_v = mem[RAddr[8:0]];
      end
      if (mem_lat == 1) begin
        RVld  <= 1'b1;
        RData <= rd_v;
      end else begin
        mem_cnt <= mem_lat - 1;
        mem_rd  <= rd_v;
      end
    end
  end

  // Monitor
  logic [31:0] hold0 = '0, hold1 = '0;
  logic        prev_rrdy = 1'b0;
  iss_t        ie;
  rsp_t        re;

  always @(negedge clk) begin
    if (!rstn) begin
      hold0     = '0;
      hold1     = '0;
      prev_rrdy = 1'b0;
    end else begin
      if (RRdy) begin
        check("rrdy_single_cycle", prev_rrdy, 0);
        if (iq.size() == 0) begin
          check("rrdy_unexpected", 1, 0);
        end else begin
          ie = iq.pop_front();
          check("raddr", RAddr, ie.addr);
          check("rwdata", RWData, ie.wdata);
          check("rwen", RWEn, ie.wen);
          check("rrdy_cycle", cyc, ie.cyc);
        end
      end else begin
        check("rwen_without_rrdy", RWEn, 0);
      end
      prev_rrdy = RRdy;

      if (M0Vld) begin
        if (rq0.size() == 0) begin
          check("m0_vld_unexpected", 1, 0);
        end else begin
          re = rq0.pop_front();
          check("m0_data", M0Data, re.data);
          check("m0_rerr", RErr, re.err);
          check("m0_vld_cycle", cyc, re.cyc);
          hold0 = re.data;
        end
      end else begin
        check("m0_data_hold", M0Data, hold0);
      end

      if (M1Vld) begin
        if (rq1.size() == 0) begin
          check("m1_vld_unexpected", 1, 0);
        end else begin
          re = rq1.pop_front();
          check("m1_data", M1Data, re.data);
          check("m1_rerr", RErr, re.err);
          check("m1_vld_cycle", cyc, re.cyc);
          hold1 = re.data;
        end
      end else begin
        check("m1_data_hold", M1Data, hold1);
      end

      if (!M0Vld && !M1Vld) check("rerr_idle", RErr, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input int off);
    iq.push_back('{a, d, w, base + off});
  endtask

  task automatic push_rsp(input int m, input logic [31:0] d, input logic e, input int off);
    if (m == 0) rq0.push_back('{d, e, base + off});
    else        rq1.push_back('{d, e, base + off});
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic w);
    if (m == 0) begin
      M0Req = 1'b1; M0Addr = a; M0WData = d; M0WEn = w;
    end else begin
      M1Req = 1'b1; M1Addr = a; M1WData = d; M1WEn = w;
    end
  endtask

  task automatic clr_req(input int m);
    if (m == 0) M0Req = 1'b0;
    else        M1Req = 1'b0;
  endtask

  // Master model: hold the request until Vld, drop it at the edge that samples Vld.
  task automatic txn(input int m, input logic [31:0] a, input logic [31:0] d, input logic w);
    bit got = 1'b0;
    set_req(m, a, d, w);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if ((m == 0 && M0Vld) || (m == 1 && M1Vld)) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL vld_wait: master %0d got no response within 64 cycles", m);
    end
    tick();
    clr_req(m);
  endtask

  task automatic check_zero_outputs();
    check("rst_rrdy", RRdy, 0);
    check("rst_rwen", RWEn, 0);
    check("rst_raddr", RAddr, 0);
    check("rst_rwdata", RWData, 0);
    check("rst_m0vld", M0Vld, 0);
    check("rst_m1vld", M1Vld, 0);
    check("rst_m0data", M0Data, 0);
    check("rst_m1data", M1Data, 0);
    check("rst_rerr", RErr, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check_zero_outputs();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h5A5A_0000 + i;
    mem['h100] = 32'hDEAD_BEEF;
    mem['h101] = 32'h0000_0011;
    mem['h102] = 32'h0000_0022;
    for (int i = 0; i < 6; i++) mem['h110 + i] = 32'hA000_0000 + i;

    tick();
    tick();
    do_reset();

    // Single M0 read: RRdy at +1, M0Vld at +3.
    base = cyc;
    push_iss(32'h100, 32'h0, 1'b0, 1);
    push_rsp(0, 32'hDEAD_BEEF, 1'b0, 3);
    txn(0, 32'h100, 32'h0, 1'b0);
    tick();

    // Simultaneous requests from reset: M0 first, M1 four cycles later.
    do_reset();
    base = cyc;
    push_iss(32'h101, 32'h0, 1'b0, 1);
    push_iss(32'h102, 32'h0, 1'b0, 5);
    push_rsp(0, 32'h11, 1'b0, 3);
    push_rsp(1, 32'h22, 1'b0, 7);
    fork
      txn(0, 32'h101, 32'h0, 1'b0);
      txn(1, 32'h102, 32'h0, 1'b0);
    join

    // Continuous requests from both: grants alternate 0,1,0,1,0,1.
    base = cyc;
    for (int i = 0; i < 6; i++) begin
      push_iss(32'h110 + i, 32'h5000_0110 + i, 1'b0, 1 + 4 * i);
      if (i % 2 == 0) push_rsp(0, 32'hA000_0000 + i, 1'b0, 3 + 4 * i);
      else            push_rsp(1, 32'hA000_0000 + i, 1'b0, 3 + 4 * i);
    end
    fork
      begin
        txn(0, 32'h110, 32'h5000_0110, 1'b0);
        txn(0, 32'h112, 32'h5000_0112, 1'b0);
        txn(0, 32'h114, 32'h5000_0114, 1'b0);
      end
      begin
        txn(1, 32'h111, 32'h5000_0111, 1'b0);
        txn(1, 32'h113, 32'h5000_0113, 1'b0);
        txn(1, 32'h115, 32'h5000_0115, 1'b0);
      end
    join

    // M1 write then M0 read-back of the same word.
    tick();
    base = cyc;
    push_iss(32'h105, 32'hCAFE_F00D, 1'b1, 1);
    push_rsp(1, 32'hBAD0_0105, 1'b0, 3);
    txn(1, 32'h105, 32'hCAFE_F00D, 1'b1);
    check("mem_word_written", mem['h105], 32'hCAFE_F00D);
    base = cyc;
    push_iss(32'h105, 32'h0, 1'b0, 1);
    push_rsp(0, 32'hCAFE_F00D, 1'b0, 3);
    txn(0, 32'h105, 32'h0, 1'b0);

    // Reset while in WAIT; the late RVld must not produce a response.
    tick();
    mem_lat = 3;
    base = cyc;
    push_iss(32'h120, 32'h77, 1'b0, 1);
    set_req(0, 32'h120, 32'h77, 1'b0);
    tick();
    tick();
    rstn = 1'b0;
    clr_req(0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check_zero_outputs();
    tick();
    repeat (6) tick();
    mem_lat = 1;
    base = cyc;
    push_iss(32'h100, 32'h0, 1'b0, 1);
    push_rsp(0, 32'hDEAD_BEEF, 1'b0, 3);
    txn(0, 32'h100, 32'h0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after 4 WAIT cycles with zero data and RErr.
    tick();
    mem_lat = 0;
    base = cyc;
    push_iss(32'h130, 32'h0, 1'b0, 1);
    push_rsp(0, 32'h0, 1'b1, 6);
    txn(0, 32'h130, 32'h0, 1'b0);
    mem_lat = 1;
    base = cyc;
    push_iss(32'h101, 32'h0, 1'b0, 1);
    push_rsp(1, 32'h11, 1'b0, 3);
    txn(1, 32'h101, 32'h0, 1'b0);
`endif

    repeat (4) tick();
    check("issue_queue_drained", iq.size(), 0);
    check("m0_queue_drained", rq0.size(), 0);
    check("m1_queue_drained", rq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
